// File: rtl/data_sram_responder.sv
// Responder end of the core's data SRAM request interface: byte-writable word memory,
// fixed-latency in-order read returns, out-of-window error flag and access counters.
module data_sram_responder #(
    parameter int unsigned DEPTH  = 16384,
    parameter logic [31:0] BASE   = 32'h1c000000,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] WIN_END  = {1'b0, BASE} + 33'(4 * DEPTH);
    localparam logic [AW-1:0] BASE_IDX = BASE[AW+1:2];

    logic          in_win;
    logic [AW-1:0] idx;
    logic          is_rd;
    logic          is_wr;

    logic [31:0] mem [DEPTH];

    logic        pipe_vld  [RD_LAT];
    logic [31:0] pipe_data [RD_LAT];

    // The window is aligned to its own size, so the word offset is just the low address bits.
    always_comb begin
        in_win = (data_sram_addr >= BASE) && ({1'b0, data_sram_addr} < WIN_END);
        idx    = data_sram_addr[AW+1:2] - BASE_IDX;
        is_rd  = data_sram_en && (data_sram_we == 4'b0000);
        is_wr  = data_sram_en && (data_sram_we != 4'b0000) && in_win;
    end

    // NOTE: the array has no reset branch so it can map onto block RAM; contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (rstn && is_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every stage shifts from its pre-edge value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld[k]  <= 1'b0;
                pipe_data[k] <= '0;
            end
            data_sram_err <= 1'b0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
        end else begin
            // Out-of-window reads still occupy a slot and return zero so the requester never stalls.
            pipe_vld[0] <= is_rd;
            if (is_rd) begin
                pipe_data[0] <= in_win ? mem[idx] : 32'h0;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
            data_sram_err <= data_sram_en && !in_win;
            if (is_rd && in_win) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (is_wr) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

    assign data_sram_rvalid = pipe_vld[RD_LAT-1];
    assign data_sram_rdata  = pipe_data[RD_LAT-1];

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (RD_LAT 1, 3, 4) share one request stream
// and are compared against a cycle-indexed history model of the memory and its responses.
module tb_data_sram_responder;
    localparam logic [31:0] BASE  = 32'h1c000000;
    localparam int          DEPTH = 16384;
    localparam int          HIST  = 8192;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] dd   [3];
    logic        dv   [3];
    logic        derr [3];
    logic [31:0] drc  [3];
    logic [31:0] dwc  [3];

    data_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rstn(rstn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(dd[0]),
        .data_sram_rvalid(dv[0]), .data_sram_err(derr[0]), .rd_cnt(drc[0]), .wr_cnt(dwc[0])
    );
    data_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rstn(rstn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(dd[1]),
        .data_sram_rvalid(dv[1]), .data_sram_err(derr[1]), .rd_cnt(drc[1]), .wr_cnt(dwc[1])
    );
    data_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(4)) u_lat4 (
        .clk(clk), .rstn(rstn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(dd[2]),
        .data_sram_rvalid(dv[2]), .data_sram_err(derr[2]), .rd_cnt(drc[2]), .wr_cnt(dwc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory by word index, and per-edge record of which edges accepted a read.
    logic [31:0] m_mem [int];
    bit          hist_rd [HIST];
    logic [31:0] hist_d  [HIST];
    int          n_edge   = 0;
    int          rst_edge = 0;
    logic [31:0] m_rc = 0;
    logic [31:0] m_wc = 0;
    bit          m_err = 0;
    bit          e_v [3];
    logic [31:0] e_d [3];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    // Drive one request across one rising edge, advance the model, return at the falling edge.
    task automatic step(input bit r, input bit e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        bit          win;
        int          idx;
        int          src;
        logic [31:0] word;
        rstn = r; en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        n_edge++;
        hist_rd[n_edge] = 1'b0;
        win = ({32'h0, a} >= {32'h0, BASE}) && ({32'h0, a} < ({32'h0, BASE} + 64'(4 * DEPTH)));
        idx = int'((a - BASE) >> 2);
        if (!r) begin
            rst_edge = n_edge;
            m_rc = 0; m_wc = 0; m_err = 0;
            for (int k = 0; k < 3; k++) e_d[k] = 32'h0;
        end else begin
            m_err = e && !win;
            if (e && w == 4'b0000) begin
                hist_rd[n_edge] = 1'b1;
                hist_d[n_edge]  = win ? m_mem[idx] : 32'h0;
                if (win) m_rc++;
            end else if (e && win) begin
                word = m_mem.exists(idx) ? m_mem[idx] : 32'hxxxxxxxx;
                for (int i = 0; i < 4; i++)
                    if (w[i]) word[8*i +: 8] = d[8*i +: 8];
                m_mem[idx] = word;
                m_wc++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            src = n_edge - lat_of(k) + 1;
            e_v[k] = (src > rst_edge) && hist_rd[src];
            if (e_v[k]) e_d[k] = hist_d[src];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        step(0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dv[k] !== 1'b0) $display("FAIL reset_rvalid lat%0d: got %b want 0", lat_of(k), dv[k]);
            else n_pass++;
            n_chk++;
            if (dd[k] !== 32'h0) $display("FAIL reset_rdata lat%0d: got %h want 0", lat_of(k), dd[k]);
            else n_pass++;
            n_chk++;
            if (derr[k] !== 1'b0) $display("FAIL reset_err lat%0d: got %b want 0", lat_of(k), derr[k]);
            else n_pass++;
            n_chk++;
            if (drc[k] !== 32'h0 || dwc[k] !== 32'h0)
                $display("FAIL reset_cnt lat%0d: got rd=%0d wr=%0d want 0/0", lat_of(k), drc[k], dwc[k]);
            else n_pass++;
        end
    endtask

    task automatic test_full_write_read;
        step(1, 1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
        step(1, 1, 4'h0, BASE + 32'h10, 32'h0);
        n_chk++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'hDEADBEEF)
            $display("FAIL full_rd lat1: got v=%b d=%h want v=1 d=deadbeef", dv[0], dd[0]);
        else n_pass++;
        n_chk++;
        if (drc[0] !== 32'd1 || dwc[0] !== 32'd1)
            $display("FAIL full_cnt: got rd=%0d wr=%0d want 1/1", drc[0], dwc[0]);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_byte_lanes;
        step(1, 1, 4'b0100, BASE + 32'h10, 32'h00AA0000);
        step(1, 1, 4'b0011, BASE + 32'h10, 32'h12341234);
        step(1, 1, 4'b0000, BASE + 32'h10, 32'h0);
        n_chk++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'hDEAA1234)
            $display("FAIL lanes lat1: got v=%b d=%h want v=1 d=deaa1234", dv[0], dd[0]);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_pipelined_reads;
        logic [31:0] a  [3] = '{BASE + 32'h100, BASE + 32'h104, BASE + 32'h108};
        bit          xv [6] = '{0, 0, 1, 1, 1, 0};
        logic [31:0] xd [6] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h33};
        step(1, 1, 4'hF, a[0], 32'h11);
        step(1, 1, 4'hF, a[1], 32'h22);
        step(1, 1, 4'hF, a[2], 32'h33);
        idle(4);
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1, 1, 4'h0, a[i], 32'h0);
            else idle(1);
            n_chk++;
            if (dv[1] !== xv[i]) $display("FAIL pipe_rvalid lat3 step%0d: got %b want %b", i, dv[1], xv[i]);
            else n_pass++;
            if (i >= 2) begin
                n_chk++;
                if (dd[1] !== xd[i]) $display("FAIL pipe_rdata lat3 step%0d: got %h want %h", i, dd[1], xd[i]);
                else n_pass++;
            end
        end
        idle(2);
    endtask

    task automatic test_out_of_window;
        logic [31:0] rc0;
        logic [31:0] wc0;
        step(1, 1, 4'hF, BASE + 32'hFFF0, 32'hCAFEF00D);
        idle(1);
        rc0 = m_rc;
        step(1, 1, 4'h0, 32'h00000000, 32'h0);
        n_chk++;
        if (derr[0] !== 1'b1 || dv[0] !== 1'b1 || dd[0] !== 32'h0)
            $display("FAIL oow_rd lat1: got err=%b v=%b d=%h want 1/1/0", derr[0], dv[0], dd[0]);
        else n_pass++;
        n_chk++;
        if (drc[0] !== rc0) $display("FAIL oow_rd_cnt: got %0d want %0d", drc[0], rc0);
        else n_pass++;
        wc0 = m_wc;
        step(1, 1, 4'hF, 32'hFFFFFFF0, 32'h55555555);
        n_chk++;
        if (derr[0] !== 1'b1 || dwc[0] !== wc0)
            $display("FAIL oow_wr: got err=%b wr=%0d want 1/%0d", derr[0], dwc[0], wc0);
        else n_pass++;
        step(1, 1, 4'h0, BASE + 32'hFFF0, 32'h0);
        n_chk++;
        if (derr[0] !== 1'b0 || dv[0] !== 1'b1 || dd[0] !== 32'hCAFEF00D)
            $display("FAIL oow_nomod: got err=%b v=%b d=%h want 0/1/cafef00d", derr[0], dv[0], dd[0]);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_reset_mid_flight;
        step(1, 1, 4'h0, BASE + 32'h100, 32'h0);
        step(1, 1, 4'h0, BASE + 32'h104, 32'h0);
        idle(1);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            n_chk++;
            if (dv[2] !== 1'b0 || drc[2] !== 32'h0 || dwc[2] !== 32'h0)
                $display("FAIL rst_flight lat4 cyc%0d: got v=%b rd=%0d wr=%0d want 0/0/0", i, dv[2], drc[2], dwc[2]);
            else n_pass++;
        end
        step(1, 1, 4'h0, BASE + 32'h108, 32'h0);
        idle(3);
        n_chk++;
        if (dv[2] !== 1'b1 || dd[2] !== 32'h33 || drc[2] !== 32'd1)
            $display("FAIL rst_keep lat4: got v=%b d=%h rd=%0d want 1/33/1", dv[2], dd[2], drc[2]);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] pool [8];
        logic [31:0] oow  [5];
        logic [31:0] a;
        int          sel;
        pool[0] = BASE;
        pool[1] = BASE + 32'(4 * DEPTH - 4);
        for (int i = 2; i < 8; i++) pool[i] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        oow = '{BASE - 32'd4, BASE + 32'(4 * DEPTH), 32'h0, 32'hFFFFFFFC, 32'h00001000};
        for (int i = 0; i < 8; i++) step(1, 1, 4'hF, pool[i], $urandom);
        for (int c = 0; c < 600; c++) begin
            sel = $urandom_range(0, 99);
            a = pool[$urandom_range(0, 7)];
            if (sel < 2)       step(0, 0, 4'h0, 32'h0, 32'h0);
            else if (sel < 20) idle(1);
            else if (sel < 30) step(1, 1, ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                                    oow[$urandom_range(0, 4)], $urandom);
            else if (sel < 65) step(1, 1, 4'h0, a, 32'h0);
            else               step(1, 1, 4'($urandom_range(1, 15)), a, $urandom);
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dv[k] !== e_v[k] || dd[k] !== e_d[k])
                    $display("FAIL rand_resp lat%0d cyc%0d: got v=%b d=%h want v=%b d=%h",
                             lat_of(k), c, dv[k], dd[k], e_v[k], e_d[k]);
                else n_pass++;
                n_chk++;
                if (derr[k] !== m_err || drc[k] !== m_rc || dwc[k] !== m_wc)
                    $display("FAIL rand_stat lat%0d cyc%0d: got err=%b rd=%0d wr=%0d want %b/%0d/%0d",
                             lat_of(k), c, derr[k], drc[k], dwc[k], m_err, m_rc, m_wc);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        test_reset;
        test_full_write_read;
        test_byte_lanes;
        test_pipelined_reads;
        test_out_of_window;
        test_reset_mid_flight;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (slave) end of the core's data SRAM request interface. The Execute stage is the initiator and drives en/we/addr/wdata with no back-pressure.
- Block holds a word-organised, byte-writable data memory and returns in-order read data after a fixed, parameterised latency.
- Flags accesses outside its address window.
- Keeps read/write access counters for the bench and for performance monitoring.
- Used as the data memory in simulation top-level and FPGA bring-up builds.

Parameters:
- DEPTH, 16384: number of 32-bit words; power of two.
- BASE, 32'h1c000000: byte base address of the window; aligned to 4*DEPTH.
- RD_LAT, 1: read latency in cycles from request edge to rvalid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous active-low reset.
- data_sram_en  in  1  request valid this cycle.
- data_sram_we  in  4  byte write enables; nonzero = write, zero = read.
- data_sram_addr  in  32  byte address; bits [1:0] ignored for the word index.
- data_sram_wdata  in  32  write data, lane-aligned by the initiator.
- data_sram_rdata  out  32  read data.
- data_sram_rvalid  out  1  read data valid; one pulse per accepted read.
- data_sram_err  out  1  registered; high for 1 cycle after an out-of-window request.
- rd_cnt  out  32  count of accepted reads.
- wr_cnt  out  32  count of accepted writes.

Behaviour:
- Reset: rstn=0 at a rising edge clears the latency pipeline, data_sram_rvalid=0, data_sram_rdata=0, data_sram_err=0, rd_cnt=0, wr_cnt=0.
  - Memory array is not cleared; contents are undefined until written.
  - Reads in flight when reset is asserted are discarded and produce no rvalid.
- Acceptance: every cycle with en=1 is accepted. There is no ready signal and at most one request per cycle.
- Window check: in_win = (addr >= BASE) && (addr < BASE + 4*DEPTH); index = (addr - BASE) >> 2.
- Out-of-window request:
  - No memory update.
  - Counters do not increment.
  - data_sram_err=1 on the next cycle.
  - For a read, a response is still issued (rvalid pulse, rdata=0) so the requester never hangs.
- Write (en=1, we!=0, in_win):
  - At the request edge, only the lanes with we[i]=1 are updated: mem[index][8i+7:8i] <= wdata[8i+7:8i].
  - Other lanes are unchanged.
  - wr_cnt increments by 1.
  - No rvalid is generated.
- Read (en=1, we=0, in_win):
  - The word is sampled at the request edge and enters stage 1 of the pipeline.
  - Stage k moves to stage k+1 on every edge.
  - data_sram_rvalid/rdata come from stage RD_LAT. A read issued in cycle t is visible in cycle t+RD_LAT.
  - RD_LAT=1 gives a registered output the cycle after the request, which matches the Memory stage's expectation.
  - rd_cnt increments by 1.
  - Back-to-back reads produce back-to-back rvalid, in order.
- Ordering:
  - A write in cycle t followed by a read of the same word in cycle t+1 returns the new data.
  - A read in cycle t is not affected by a write to the same word in cycle t+1 (the read data was already sampled).
- Idle cycles (en=0):
  - Pipeline stages shift in empty entries.
  - rvalid is 0 when the output stage is empty.
  - rdata holds its last valid value.
- Counters: 32-bit, wrap from 32'hFFFFFFFF to 0 with no sticky flag.
- Lane usage: the block does not check that `we` matches address alignment. The initiator raises ALE and suppresses the write itself.

Test Plan:
- Reset with RD_LAT=1: hold rstn=0 for 2 cycles -> rvalid=0, rdata=0, err=0, rd_cnt=wr_cnt=0.
- Full write then read: write addr 0x1c000010, we=4'b1111, wdata=0xDEADBEEF; read the same address next cycle -> rvalid=1 one cycle later, rdata=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
- Byte and half lanes: after the previous test, write we=4'b0100 with wdata=0x00AA0000, then we=4'b0011 with wdata=0x12341234, then read -> rdata=0xDEAA1234.
- Pipelined reads with RD_LAT=3: reads of words holding 0x11, 0x22, 0x33 in cycles 10, 11, 12 -> rvalid in cycles 13, 14, 15 with rdata 0x11, 0x22, 0x33 in order; no rvalid in cycle 16.
- Out of window: read 0x00000000 -> cycle+1 err=1, rvalid=1, rdata=0, rd_cnt unchanged; write 0xFFFFFFF0 -> err=1, no memory change, wr_cnt unchanged.
- Reset mid-flight with RD_LAT=4: issue 2 reads, assert rstn=0 for 1 cycle two cycles later -> no rvalid afterward, counters=0; earlier written data readable after reset.
